core_arbiter: RTL and testbench

Shares the 20-stage arithmetic `core` pipeline between `NUM_REQ` requesters. It performs round-robin arbitration with a valid/ready handshake and drives `core.data_in`. A tag pipeline tracks each operand through the fixed core latency, and each result is returned with its requester ID. Per-requester outstanding limits and a hold/drain state machine let the system quiesce the pipeline safely.

---
 rtl/core_arb_pkg.sv | 20 ++
 rtl/core_arb_rr.sv | 44 ++++
 rtl/core_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_core_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_arb_pkg.sv
// Shared types and constants for the core pipeline arbiter.
package core_arb_pkg;

  localparam int PIPE_LAT  = 20;
  localparam int TAG_DEPTH = PIPE_LAT + 1;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W  = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/core_arb_rr.sv
// Round-robin picker: first eligible index at or after ptr, wrapping modulo N.
module core_arb_rr
  import core_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   pos_s;
  logic [IW-1:0] cand_s;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    gnt    = {N{1'b0}};
    idx    = {IW{1'b0}};
    any    = 1'b0;
    pos_s  = {(IW+1){1'b0}};
    cand_s = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      pos_s = {1'b0, ptr} + (IW+1)'(k);
      if (pos_s >= (IW+1)'(N)) begin
        pos_s = pos_s - (IW+1)'(N);
      end else begin
        pos_s = pos_s;
      end
      cand_s = pos_s[IW-1:0];
      if (elig[cand_s]) begin
        gnt         = {N{1'b0}};
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/core_arbiter.sv
// Shares the 20-stage core between NUM_REQ requesters with round-robin grant,
// a tag pipeline aligned to the core latency, and a hold/drain/halt controller.
module core_arbiter
  import core_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int MAX_OUT = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]         core_data_in,
  input  logic [DATA_W-1:0]         core_data_out,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      hold,
  output logic                      halted,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int INF_W = $clog2(TAG_DEPTH + 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [NUM_REQ];
  logic [CNT_W-1:0]  cnt_d [NUM_REQ];
  logic [INF_W-1:0]  inflight_q, inflight_d;
  tag_t              tag_q [TAG_DEPTH];
  tag_t              tag_d [TAG_DEPTH];
  logic [DATA_W-1:0] core_data_in_q, core_data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              halted_q, busy_q;

  logic [NUM_REQ-1:0] elig_s, gnt_s;
  logic [ID_W-1:0]    win_idx_s;
  logic               any_s, accept_s, rsp_fire_s;
  logic [DATA_W-1:0]  win_data_s;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) && (state_q == RUN);
    end
  end

  core_arb_rr #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .elig (elig_s),
    .ptr  (rr_ptr_q),
    .gnt  (gnt_s),
    .idx  (win_idx_s),
    .any  (any_s)
  );

  assign req_ready  = rst_n ? gnt_s : {NUM_REQ{1'b0}};
  assign accept_s   = rst_n && any_s;
  assign rsp_fire_s = tag_q[TAG_DEPTH-1].valid;

  always_comb begin
    win_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        win_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  always_comb begin
    core_data_in_d = accept_s ? win_data_s : core_data_in_q;
    if (accept_s) begin
      rr_ptr_d = (win_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : win_idx_s + ID_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    tag_d[0] = accept_s ? '{valid: 1'b1, id: TAG_ID_W'(win_idx_s)}
                        : '{valid: 1'b0, id: {TAG_ID_W{1'b0}}};
    for (int k = 1; k < TAG_DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rsp_valid_d = rsp_fire_s;
    rsp_id_d    = rsp_fire_s ? tag_q[TAG_DEPTH-1].id[ID_W-1:0] : rsp_id_q;
    rsp_data_d  = rsp_fire_s ? core_data_out : rsp_data_q;
  end

  // A simultaneous accept and response for the same owner cancel out.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_s && (win_idx_s == ID_W'(i)) &&
          !(rsp_fire_s && (tag_q[TAG_DEPTH-1].id == TAG_ID_W'(i)))) begin
        cnt_d[i] = (cnt_q[i] < CNT_W'(MAX_OUT)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      end else if (rsp_fire_s && (tag_q[TAG_DEPTH-1].id == TAG_ID_W'(i)) &&
                   !(accept_s && (win_idx_s == ID_W'(i))) && (cnt_q[i] != {CNT_W{1'b0}})) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    if (accept_s && !(rsp_fire_s && (inflight_q != {INF_W{1'b0}}))) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!accept_s && rsp_fire_s && (inflight_q != {INF_W{1'b0}})) begin
      inflight_d = inflight_q - INF_W'(1);
    end else begin
      inflight_d = inflight_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        state_d = hold ? DRAIN : RUN;
      end
      DRAIN: begin
        if (!hold) begin
          state_d = RUN;
        end else if ((inflight_q == {INF_W{1'b0}}) && !rsp_fire_s) begin
          state_d = HALTED;
        end else begin
          state_d = DRAIN;
        end
      end
      HALTED: begin
        state_d = hold ? HALTED : RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      rr_ptr_q       <= {ID_W{1'b0}};
      inflight_q     <= {INF_W{1'b0}};
      core_data_in_q <= {DATA_W{1'b0}};
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= {ID_W{1'b0}};
      rsp_data_q     <= {DATA_W{1'b0}};
      halted_q       <= 1'b0;
      busy_q         <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      for (int k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= '{valid: 1'b0, id: {TAG_ID_W{1'b0}}};
      end
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      inflight_q     <= inflight_d;
      core_data_in_q <= core_data_in_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
      halted_q       <= (state_d == HALTED);
      busy_q         <= (inflight_d != {INF_W{1'b0}});
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      for (int k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign core_data_in = core_data_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign halted       = halted_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_core_arbiter.sv
// Bench for core_arbiter with a behavioural 20-stage adder core and a
// queue-based reference model of arbitration, latency and hold/drain.
module core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  localparam logic [DATA_W-1:0] ADD_K = DATA_W'(32'h86E52C7B);
  logic [DATA_W-1:0] stg_q [20];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 20; k++) stg_q[k] <= '0;
    end else begin
      stg_q[0] <= data_in + ADD_K;
      for (int k = 1; k < 20; k++) stg_q[k] <= stg_q[k-1];
    end
  end

  assign data_out = stg_q[19];
endmodule

module tb_core_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int MO  = 8;
  localparam int IW  = 2;
  localparam int LAT = 21;
  localparam logic [31:0] K = 32'h86E52C7B;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0]   core_data_in, core_data_out;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            halted, busy;

  always #10 clk = ~clk;

  core_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .hold(hold), .halted(halted), .busy(busy)
  );

  core #(.DATA_W(DW)) u_core (
    .clk(clk), .rst_n(rst_n), .data_in(core_data_in), .data_out(core_data_out)
  );

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] r;
  } vec_t;

  pend_t       pq[$];
  int          acc_q[$];
  int          m_cnt [N];
  int          m_inf, m_ptr, m_state;
  logic [31:0] m_cin, m_rd;
  logic        m_rv, m_halted, m_busy;
  logic [IW-1:0] m_rid;
  int          cyc, checks, errors, acc_count, rsp_seen;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (v[j] && m_cnt[j] < MO && m_state == 0) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_inf = 0; m_ptr = 0; m_state = 0;
    m_cin = '0; m_rv = 1'b0; m_rid = '0; m_rd = '0;
    m_halted = 1'b0; m_busy = 1'b0;
  endtask

  // One clock: check the combinational grant, advance the model, check registers.
  task automatic step();
    int    w, inf_before;
    logic  resp_now;
    pend_t p;
    @(negedge clk);
    w = rst_n ? pick(req_valid) : -1;
    chk("req_ready", 64'(req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      inf_before = m_inf;
      resp_now = (pq.size() > 0) && (pq[0].due == cyc);
      if (resp_now) begin
        p = pq.pop_front();
        m_rv = 1'b1; m_rid = p.id[IW-1:0]; m_rd = p.data + K;
        m_cnt[p.id]--; m_inf--;
      end else begin
        m_rv = 1'b0;
      end
      if (w >= 0) begin
        acc_count++;
        acc_q.push_back(w);
        m_cin = req_data[w*DW +: DW];
        pq.push_back('{cyc + LAT, w, m_cin});
        m_cnt[w]++; m_inf++;
        m_ptr = (w + 1) % N;
      end
      case (m_state)
        0: if (hold) m_state = 1;
        1: if (!hold) m_state = 0; else if (inf_before == 0 && !resp_now) m_state = 2;
        2: if (!hold) m_state = 0;
        default: m_state = 0;
      endcase
      m_halted = (m_state == 2);
      m_busy   = (m_inf != 0);
    end
    #1;
    if (rsp_valid === 1'b1) rsp_seen++;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("rsp_id", 64'(rsp_id), 64'(m_rid));
    chk("rsp_data", 64'(rsp_data), 64'(m_rd));
    chk("core_data_in", 64'(core_data_in), 64'(m_cin));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("halted", 64'(halted), 64'(m_halted));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  vec_t tbl [7];
  int   rr_exp [5];

  initial begin
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 4'b0001};
    tbl[2] = '{4'b0110, 4'b0010};
    tbl[3] = '{4'b1000, 4'b1000};
    tbl[4] = '{4'b1111, 4'b0001};
    tbl[5] = '{4'b1100, 4'b0100};
    tbl[6] = '{4'b1010, 4'b0010};
    rr_exp = '{0, 1, 2, 3, 0};
    checks = 0; errors = 0; cyc = 0;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(1);

    // Grant table with rr_ptr at 0, all counters empty, no clock edge in between
    for (int t = 0; t < 7; t++) begin
      req_valid = tbl[t].v;
      #1;
      chk("grant_tbl", 64'(req_ready), 64'(tbl[t].r));
    end
    req_valid = '0;
    steps(1);

    // Single request from requester 2 with zero operand
    req_data = '0;
    req_valid = 4'b0100;
    steps(1);
    req_valid = '0;
    chk("single_busy", 64'(busy), 64'd1);
    steps(20);
    chk("single_early", 64'(rsp_valid), 64'd0);
    steps(1);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_data", 64'(rsp_data), 64'h86E52C7B);
    steps(1);
    chk("single_idle", 64'(busy), 64'd0);

    // Round robin from rr_ptr 0
    rst_n = 1'b0;
    steps(1);
    rst_n = 1'b1;
    acc_q.delete();
    rand_data();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      steps(1);
      rand_data();
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(acc_q[i]), 64'(rr_exp[i]));
    steps(25);

    // Outstanding limit on requester 1
    acc_count = 0;
    req_valid = 4'b0010;
    for (int i = 0; i < 21; i++) begin
      rand_data();
      steps(1);
    end
    chk("limit_accepts", 64'(acc_count), 64'd8);
    for (int i = 0; i < 20; i++) begin
      rand_data();
      steps(1);
    end
    req_valid = '0;
    steps(30);

    // Hold with 5 in flight
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      steps(1);
    end
    hold = 1'b1;
    req_valid = '0;
    steps(1);
    acc_count = 0;
    req_valid = 4'b1111;
    steps(30);
    chk("hold_no_accept", 64'(acc_count), 64'd0);
    chk("hold_halted", 64'(halted), 64'd1);
    hold = 1'b0;
    steps(2);
    chk("hold_resume", 64'(acc_count), 64'd1);
    req_valid = '0;
    steps(25);

    // Reset with 10 in flight
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      steps(1);
    end
    rst_n = 1'b0;
    steps(1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    req_valid = '0;
    rsp_seen = 0;
    steps(30);
    chk("rst_no_rsp", 64'(rsp_seen), 64'd0);
    req_data[2*DW +: DW] = 32'h1234_5678;
    req_valid = 4'b0100;
    steps(1);
    req_valid = '0;
    steps(21);
    chk("rst_new_rsp", 64'(rsp_valid), 64'd1);
    chk("rst_new_data", 64'(rsp_data), 64'(32'h1234_5678 + K));

    // Randomized traffic with occasional hold toggles
    for (int i = 0; i < 600; i++) begin
      req_valid = (i < 300) ? N'($urandom) : (N'($urandom) & 4'b1001);
      rand_data();
      if ($urandom_range(0, 24) == 0) hold = ~hold;
      steps(1);
    end
    hold = 1'b0;
    req_valid = '0;
    steps(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
